// File: rtl/data_mem_responder_if.sv
// Data-memory request/response bundle between the MEM stage (master) and
// the memory responder (slave).
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts one load/store, waits WAIT_CYCLES cycles,
// then returns a single-cycle response. Byte/half/word lanes, load
// extension, error detection and saturating access counters.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2,
  parameter int CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  data_mem_responder_if.slave  bus,
  output logic [CNT_W-1:0]     load_cnt,
  output logic [CNT_W-1:0]     store_cnt,
  output logic [CNT_W-1:0]     err_cnt
);

  localparam int          IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [29:0] DEPTH_LIM = 30'(DEPTH_WORDS);
  localparam logic [3:0]  WAIT_LAST = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
  localparam bit          NO_WAIT   = (WAIT_CYCLES == 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      stateR;
  logic [3:0]  waitCntR;
  logic        weR;
  logic [31:0] addrR;
  logic [31:0] wdataR;
  logic [1:0]  sizeR;
  logic        unsR;

  logic [31:0] mem [DEPTH_WORDS];

  logic              acceptS;
  logic              enterRespS;
  logic              effWeS;
  logic [31:0]       effAddrS;
  logic [31:0]       effWdataS;
  logic [1:0]        effSizeS;
  logic              effUnsS;
  logic              errS;
  logic [IDX_W-1:0]  idxS;
  logic [31:0]       memWordS;
  logic [31:0]       loadDataS;
  logic [3:0]        laneS;
  logic [31:0]       wdRepS;
  logic              memWeS;

  // Request is malformed: illegal size, misaligned, or beyond storage
  function automatic logic isBadReq(input logic [31:0] addr, input logic [1:0] size);
    logic bad;
    case (size)
      2'b00:   bad = 1'b0;
      2'b01:   bad = addr[0];
      2'b10:   bad = |addr[1:0];
      default: bad = 1'b1;
    endcase
    if (addr[31:2] >= DEPTH_LIM) begin
      bad = 1'b1;
    end else begin
      bad = bad;
    end
    return bad;
  endfunction

  // Pick the addressed byte/half out of a word and sign/zero extend it
  function automatic logic [31:0] extractLoad(input logic [31:0] word, input logic [1:0] off,
                                              input logic [1:0] size, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = 8'(word >> {off, 3'b000});
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   r = uns ? {24'd0, b} : {{24{b[7]}}, b};
      2'b01:   r = uns ? {16'd0, h} : {{16{h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Little-endian byte lanes touched by a store
  function automatic logic [3:0] laneMask(input logic [1:0] off, input logic [1:0] size);
    logic [3:0] m;
    case (size)
      2'b00:   m = 4'b0001 << off;
      2'b01:   m = off[1] ? 4'b1100 : 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  // Counter increment that sticks at all-ones
  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] cnt);
    return (cnt == {CNT_W{1'b1}}) ? cnt : cnt + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  assign acceptS = bus.req_valid & bus.req_ready;

  // Request fields seen at RESP entry: live inputs when there is no wait, latched copy otherwise
  always_comb begin
    if (NO_WAIT) begin
      effWeS    = bus.req_we;
      effAddrS  = bus.req_addr;
      effWdataS = bus.req_wdata;
      effSizeS  = bus.req_size;
      effUnsS   = bus.req_unsigned;
    end else begin
      effWeS    = weR;
      effAddrS  = addrR;
      effWdataS = wdataR;
      effSizeS  = sizeR;
      effUnsS   = unsR;
    end
  end

  // Detect the edge that moves the FSM into RESP
  always_comb begin
    enterRespS = 1'b0;
    case (stateR)
      S_IDLE:  enterRespS = NO_WAIT && acceptS;
      S_WAIT:  enterRespS = (waitCntR == WAIT_LAST);
      default: enterRespS = 1'b0;
    endcase
  end

  // Decode access: error check, word read, load extraction, store lane data
  always_comb begin
    errS      = isBadReq(effAddrS, effSizeS);
    idxS      = effAddrS[IDX_W+1:2];
    memWordS  = mem[idxS];
    loadDataS = extractLoad(memWordS, effAddrS[1:0], effSizeS, effUnsS);
    laneS     = laneMask(effAddrS[1:0], effSizeS);
    case (effSizeS)
      2'b00:   wdRepS = {4{effWdataS[7:0]}};
      2'b01:   wdRepS = {2{effWdataS[15:0]}};
      default: wdRepS = effWdataS;
    endcase
    memWeS = enterRespS & effWeS & ~errS & reset;
  end

  // Lane-masked storage write on RESP entry; storage is deliberately not reset
  always_ff @(posedge clk) begin
    if (memWeS) begin
      for (int i = 0; i < 4; i++) begin
        if (laneS[i]) begin
          mem[idxS][i*8 +: 8] <= wdRepS[i*8 +: 8];
        end
      end
    end
  end

  // Control FSM with registered handshake, response and counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateR         <= S_IDLE;
      waitCntR       <= 4'd0;
      weR            <= 1'b0;
      addrR          <= 32'd0;
      wdataR         <= 32'd0;
      sizeR          <= 2'b00;
      unsR           <= 1'b0;
      bus.req_ready  <= 1'b1;
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= 32'd0;
      bus.resp_err   <= 1'b0;
      load_cnt       <= {CNT_W{1'b0}};
      store_cnt      <= {CNT_W{1'b0}};
      err_cnt        <= {CNT_W{1'b0}};
    end else begin
      bus.resp_valid <= enterRespS;
      if (enterRespS) begin
        bus.resp_err   <= errS;
        bus.resp_rdata <= (errS || effWeS) ? 32'd0 : loadDataS;
        if (errS) begin
          err_cnt <= satInc(err_cnt);
        end else if (effWeS) begin
          store_cnt <= satInc(store_cnt);
        end else begin
          load_cnt <= satInc(load_cnt);
        end
      end
      case (stateR)
        S_IDLE: begin
          if (acceptS) begin
            weR           <= bus.req_we;
            addrR         <= bus.req_addr;
            wdataR        <= bus.req_wdata;
            sizeR         <= bus.req_size;
            unsR          <= bus.req_unsigned;
            waitCntR      <= 4'd0;
            bus.req_ready <= 1'b0;
            stateR        <= NO_WAIT ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          if (enterRespS) begin
            stateR <= S_RESP;
          end else begin
            waitCntR <= waitCntR + 4'd1;
          end
        end
        S_RESP: begin
          stateR        <= S_IDLE;
          bus.req_ready <= 1'b1;
        end
        default: begin
          stateR        <= S_IDLE;
          bus.req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: one default build (2 wait states)
// and one zero-wait build with 4-bit counters for saturation.
module tb_data_mem_responder;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  logic [15:0] loadCntA, storeCntA, errCntA;
  logic [3:0]  loadCntB, storeCntB, errCntB;

  data_mem_responder_if busA ();
  data_mem_responder_if busB ();

  data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2), .CNT_W(16)) dutA (
    .clk(clk), .reset(reset), .bus(busA),
    .load_cnt(loadCntA), .store_cnt(storeCntA), .err_cnt(errCntA)
  );

  data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0), .CNT_W(4)) dutB (
    .clk(clk), .reset(reset), .bus(busB),
    .load_cnt(loadCntB), .store_cnt(storeCntB), .err_cnt(errCntB)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One full transaction on DUT A, checking latency, data, error and strobe width
  task automatic txn(input string tag, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [1:0] size, input logic uns,
                     input logic [31:0] expData, input logic expErr);
    int n;
    int lat;
    n = 0;
    @(negedge clk);
    while (!busA.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "/ready"}, 32'(busA.req_ready), 32'd1);
    busA.req_we       = we;
    busA.req_addr     = addr;
    busA.req_wdata    = wdata;
    busA.req_size     = size;
    busA.req_unsigned = uns;
    busA.req_valid    = 1'b1;
    @(posedge clk);
    #1;
    busA.req_valid    = 1'b0;
    busA.req_addr     = 32'hFFFF_FFFC;
    busA.req_wdata    = ~wdata;
    busA.req_size     = 2'b11;
    busA.req_we       = ~we;
    lat = 0;
    while (!busA.resp_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, "/latency"}, 32'(lat), 32'd2);
    chk({tag, "/rdata"}, busA.resp_rdata, expData);
    chk({tag, "/err"}, 32'(busA.resp_err), 32'(expErr));
    @(posedge clk);
    #1;
    chk({tag, "/strobe1cyc"}, 32'(busA.resp_valid), 32'd0);
  endtask

  initial begin
    int acc;
    int prev;
    int n;
    clk = 1'b0;
    reset = 1'b0;
    errors = 0;
    checks = 0;
    busA.req_valid = 1'b0; busA.req_we = 1'b0; busA.req_addr = 32'd0;
    busA.req_wdata = 32'd0; busA.req_size = 2'b10; busA.req_unsigned = 1'b0;
    busB.req_valid = 1'b0; busB.req_we = 1'b0; busB.req_addr = 32'd0;
    busB.req_wdata = 32'd0; busB.req_size = 2'b10; busB.req_unsigned = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst/ready", 32'(busA.req_ready), 32'd1);
    chk("rst/valid", 32'(busA.resp_valid), 32'd0);
    chk("rst/rdata", busA.resp_rdata, 32'd0);
    chk("rst/err", 32'(busA.resp_err), 32'd0);
    chk("rst/cnts", {loadCntA, storeCntA}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Basic word store/load
    txn("st_w10", 1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, 32'd0, 1'b0);
    txn("ld_w10", 1'b0, 32'h10, 32'd0, 2'b10, 1'b0, 32'hDEADBEEF, 1'b0);
    chk("cnt/store1", 32'(storeCntA), 32'd1);
    chk("cnt/load1", 32'(loadCntA), 32'd1);

    // Lane merge and extension
    txn("st_w20", 1'b1, 32'h20, 32'h11223344, 2'b10, 1'b0, 32'd0, 1'b0);
    txn("st_b21", 1'b1, 32'h21, 32'h00000080, 2'b00, 1'b0, 32'd0, 1'b0);
    txn("ld_w20", 1'b0, 32'h20, 32'd0, 2'b10, 1'b0, 32'h11228044, 1'b0);
    txn("ld_bs21", 1'b0, 32'h21, 32'd0, 2'b00, 1'b0, 32'hFFFFFF80, 1'b0);
    txn("ld_bu21", 1'b0, 32'h21, 32'd0, 2'b00, 1'b1, 32'h00000080, 1'b0);
    txn("ld_hs22", 1'b0, 32'h22, 32'd0, 2'b01, 1'b0, 32'h00001122, 1'b0);
    txn("st_h12", 1'b1, 32'h12, 32'h0000A5B6, 2'b01, 1'b0, 32'd0, 1'b0);
    txn("ld_hs12", 1'b0, 32'h12, 32'd0, 2'b01, 1'b0, 32'hFFFFA5B6, 1'b0);

    // Error cases
    txn("e_h23", 1'b1, 32'h23, 32'h0000FFFF, 2'b01, 1'b0, 32'd0, 1'b1);
    txn("e_w22", 1'b1, 32'h22, 32'hFFFFFFFF, 2'b10, 1'b0, 32'd0, 1'b1);
    txn("e_sz3", 1'b0, 32'h20, 32'd0, 2'b11, 1'b0, 32'd0, 1'b1);
    txn("e_oor", 1'b1, 32'h410, 32'h00000000, 2'b10, 1'b0, 32'd0, 1'b1);
    txn("ld_w20b", 1'b0, 32'h20, 32'd0, 2'b10, 1'b0, 32'h11228044, 1'b0);
    txn("ld_w10b", 1'b0, 32'h10, 32'd0, 2'b10, 1'b0, 32'hA5B6BEEF, 1'b0);
    chk("cnt/err4", 32'(errCntA), 32'd4);
    chk("cnt/store4", 32'(storeCntA), 32'd4);
    chk("cnt/load8", 32'(loadCntA), 32'd8);

    // Continuous req_valid: accepts every 4 cycles
    @(negedge clk);
    busA.req_we = 1'b0; busA.req_addr = 32'h10; busA.req_size = 2'b10;
    busA.req_unsigned = 1'b0; busA.req_valid = 1'b1;
    acc = 0;
    prev = -1;
    for (int c = 0; c < 12; c++) begin
      if (busA.req_ready) begin
        acc++;
        if (prev >= 0) chk("cont/spacing", 32'(c - prev), 32'd4);
        prev = c;
      end
      @(negedge clk);
    end
    busA.req_valid = 1'b0;
    chk("cont/accepts", 32'(acc), 32'd3);
    chk("cont/load11", 32'(loadCntA), 32'd11);

    // Reset during WAIT of a store
    txn("st_w40", 1'b1, 32'h40, 32'h12345678, 2'b10, 1'b0, 32'd0, 1'b0);
    txn("ld_w40", 1'b0, 32'h40, 32'd0, 2'b10, 1'b0, 32'h12345678, 1'b0);
    @(negedge clk);
    busA.req_we = 1'b1; busA.req_addr = 32'h40; busA.req_wdata = 32'hCAFEF00D;
    busA.req_size = 2'b10; busA.req_valid = 1'b1;
    @(posedge clk);
    #1;
    busA.req_valid = 1'b0;
    chk("abort/busy", 32'(busA.req_ready), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort/ready", 32'(busA.req_ready), 32'd1);
    chk("abort/valid", 32'(busA.resp_valid), 32'd0);
    chk("abort/rdata", busA.resp_rdata, 32'd0);
    chk("abort/cnts", {8'd0, loadCntA[7:0], storeCntA[7:0], errCntA[7:0]}, 32'd0);
    txn("ld_w40c", 1'b0, 32'h40, 32'd0, 2'b10, 1'b0, 32'h12345678, 1'b0);
    chk("abort/load1", 32'(loadCntA), 32'd1);

    // Zero-wait build with saturating 4-bit counters
    for (int i = 0; i < 17; i++) begin
      n = 0;
      @(negedge clk);
      while (!busB.req_ready && n < 10) begin
        @(negedge clk);
        n++;
      end
      busB.req_we = 1'b1; busB.req_addr = 32'(i * 4); busB.req_wdata = 32'h100 + 32'(i);
      busB.req_size = 2'b10; busB.req_valid = 1'b1;
      @(posedge clk);
      #1;
      busB.req_valid = 1'b0;
      chk("B/resp_now", 32'(busB.resp_valid), 32'd1);
      chk("B/busy", 32'(busB.req_ready), 32'd0);
      if (i == 13) chk("B/cnt14", 32'(storeCntB), 32'hE);
      if (i == 14) chk("B/cnt15", 32'(storeCntB), 32'hF);
    end
    chk("B/cnt_sat", 32'(storeCntB), 32'hF);
    @(negedge clk);
    @(negedge clk);
    busB.req_we = 1'b0; busB.req_addr = 32'h20; busB.req_size = 2'b10;
    busB.req_unsigned = 1'b0; busB.req_valid = 1'b1;
    @(posedge clk);
    #1;
    busB.req_valid = 1'b0;
    chk("B/ld_valid", 32'(busB.resp_valid), 32'd1);
    chk("B/ld_rdata", busB.resp_rdata, 32'h108);
    @(posedge clk);
    #1;
    chk("B/ld_1cyc", 32'(busB.resp_valid), 32'd0);
    chk("B/load1", 32'(loadCntB), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
